hash_mem_responder: RTL

// Memory-side responder for the bitcoin_hash coprocessor's memory master port (mem_we/mem_addr/
// mem_write_data/mem_read_data). Owns a DEPTH x 32 dual-port word store and services coprocessor

---
 rtl/hash_mem_pkg.sv | 20 ++
 rtl/dp_word_ram.sv | 43 ++++
 rtl/hash_mem_responder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/hash_mem_pkg.sv
// Shared types and helpers for the bitcoin_hash memory responder.
// Holds the sequencer state encoding, the out-of-range read pattern and a rotate helper.
package hash_mem_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StStart,
        StWait,
        StDone
    } resp_state_t;

    localparam logic [31:0] BadDataDefault = 32'hDEADBEEF;

    // Using (0 - n) as the right-shift amount keeps n = 0 well defined.
    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
        return (x << n) | (x >> (5'd0 - n));
    endfunction

endpackage

// File: rtl/dp_word_ram.sv
// Word store with one write port and two independently enabled registered read ports.
// Reads sample the array before the same-edge write, so a read/write collision returns old data.
module dp_word_ram #(
    parameter int unsigned Depth = 64,
    parameter int unsigned IdxW  = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [IdxW-1:0] waddr,
    input  logic [31:0]     wdata,
    input  logic            re_a,
    input  logic [IdxW-1:0] raddr_a,
    output logic [31:0]     rdata_a,
    input  logic            re_b,
    input  logic [IdxW-1:0] raddr_b,
    output logic [31:0]     rdata_b
);

    logic [31:0] mem_q [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Only the read registers are reset; the array contents are left alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (re_a) begin
                rdata_a <= mem_q[raddr_a];
            end
            if (re_b) begin
                rdata_b <= mem_q[raddr_b];
            end
        end
    end

endmodule

// File: rtl/hash_mem_responder.sv
// Memory-side responder for the bitcoin_hash coprocessor: header loader, start strobe,
// coprocessor read/write port and an independent host read port over one word store.
module hash_mem_responder
    import hash_mem_pkg::*;
#(
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned HDR_WORDS    = 19,
    parameter int unsigned START_CYCLES = 2,
    parameter logic [31:0] BAD_DATA     = BadDataDefault
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_go,
    input  logic [31:0]       cfg_seed,
    input  logic [ADDR_W-1:0] cfg_msg_addr,
    output logic              busy,
    output logic              seq_done,
    output logic              cop_start,
    input  logic              cop_done,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_write_data,
    output logic [31:0]       mem_read_data,
    input  logic              host_re,
    input  logic [ADDR_W-1:0] host_addr,
    output logic [31:0]       host_rdata,
    output logic              host_rvalid,
    output logic [15:0]       wr_count,
    output logic              addr_err
);

    localparam int unsigned RamW   = $clog2(DEPTH);
    localparam int unsigned FillW  = $clog2(HDR_WORDS + 1);
    localparam int unsigned StartW = $clog2(START_CYCLES + 1);
    localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

    resp_state_t       state_q, state_d;
    logic [FillW-1:0]  fill_idx_q, fill_idx_d;
    logic [31:0]       fill_word_q, fill_word_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [StartW-1:0] start_cnt_q, start_cnt_d;
    logic [15:0]       wr_count_q, wr_count_d;
    logic              addr_err_q, addr_err_d;
    logic              rd_bad_q, host_bad_q, host_rvalid_q;

    logic              go_ok, cop_in, host_in, fill_in, fill_wr;
    logic [ADDR_W-1:0] fill_addr;
    logic              ram_we;
    logic [RamW-1:0]   ram_waddr;
    logic [31:0]       ram_wdata, ram_rdata_a, ram_rdata_b;

    assign go_ok     = cfg_go && (state_q == StIdle || state_q == StDone);
    assign fill_addr = base_q + ADDR_W'(fill_idx_q);
    assign cop_in    = {1'b0, mem_addr} < DepthLim;
    assign host_in   = {1'b0, host_addr} < DepthLim;
    assign fill_in   = {1'b0, fill_addr} < DepthLim;
    // A coprocessor write in the same cycle takes the write port and stalls the fill.
    assign fill_wr   = (state_q == StFill) && !mem_we && !reset;

    assign ram_we    = (mem_we && cop_in) || (fill_wr && fill_in);
    assign ram_waddr = mem_we ? mem_addr[RamW-1:0] : fill_addr[RamW-1:0];
    assign ram_wdata = mem_we ? mem_write_data : fill_word_q;

    dp_word_ram #(
        .Depth (DEPTH),
        .IdxW  (RamW)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .re_a    (!mem_we && cop_in),
        .raddr_a (mem_addr[RamW-1:0]),
        .rdata_a (ram_rdata_a),
        .re_b    (host_re && host_in),
        .raddr_b (host_addr[RamW-1:0]),
        .rdata_b (ram_rdata_b)
    );

    always_comb begin
        state_d     = state_q;
        fill_idx_d  = fill_idx_q;
        fill_word_d = fill_word_q;
        base_d      = base_q;
        start_cnt_d = start_cnt_q;
        case (state_q)
            StIdle, StDone: begin
                if (cfg_go) begin
                    state_d     = StFill;
                    fill_idx_d  = '0;
                    fill_word_d = cfg_seed;
                    base_d      = cfg_msg_addr;
                end
            end
            StFill: begin
                if (!mem_we) begin
                    fill_word_d = rotl32(fill_word_q, 5'd1);
                    if (fill_idx_q == FillW'(HDR_WORDS - 1)) begin
                        state_d     = StStart;
                        start_cnt_d = '0;
                    end else begin
                        fill_idx_d = fill_idx_q + FillW'(1);
                    end
                end
            end
            StStart: begin
                if (start_cnt_q == StartW'(START_CYCLES - 1)) begin
                    state_d = StWait;
                end else begin
                    start_cnt_d = start_cnt_q + StartW'(1);
                end
            end
            StWait: begin
                if (cop_done) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // An error raised in the cycle of an accepted cfg_go is kept, not lost to the clear.
    always_comb begin
        wr_count_d = wr_count_q;
        addr_err_d = addr_err_q;
        if (go_ok) begin
            wr_count_d = '0;
            addr_err_d = 1'b0;
        end else if (mem_we && cop_in && wr_count_q != 16'hFFFF) begin
            wr_count_d = wr_count_q + 16'd1;
        end
        if (!cop_in || (host_re && !host_in) || (fill_wr && !fill_in)) begin
            addr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            fill_idx_q    <= '0;
            fill_word_q   <= '0;
            base_q        <= '0;
            start_cnt_q   <= '0;
            wr_count_q    <= '0;
            addr_err_q    <= 1'b0;
            rd_bad_q      <= 1'b0;
            host_bad_q    <= 1'b0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fill_idx_q    <= fill_idx_d;
            fill_word_q   <= fill_word_d;
            base_q        <= base_d;
            start_cnt_q   <= start_cnt_d;
            wr_count_q    <= wr_count_d;
            addr_err_q    <= addr_err_d;
            host_rvalid_q <= host_re;
            if (!mem_we) begin
                rd_bad_q <= !cop_in;
            end
            if (host_re) begin
                host_bad_q <= !host_in;
            end
        end
    end

    assign busy          = (state_q == StFill) || (state_q == StStart) || (state_q == StWait);
    assign seq_done      = (state_q == StDone);
    assign cop_start     = (state_q == StStart);
    assign mem_read_data = rd_bad_q ? BAD_DATA : ram_rdata_a;
    assign host_rdata    = host_bad_q ? BAD_DATA : ram_rdata_b;
    assign host_rvalid   = host_rvalid_q;
    assign wr_count      = wr_count_q;
    assign addr_err      = addr_err_q;

endmodule
